// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM state enum and the default operand width.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PREP  = 2'b01,
    S_RUN   = 2'b10,
    S_FIXUP = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> mul/div unit bundle. The master side is the pipeline (EX),
// the slave side is the muldiv_ctrl sequencer.
interface muldiv_ctrl_if #(parameter int WIDTH = muldiv_pkg::WIDTH_DEFAULT);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hilo_rd;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, flush, hilo_rd,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hilo_rd,
    output busy, stall, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared mul/div loop.
// Multiply: shift-add on the {acc, q} pair, q holds the multiplier and
// collects the low product bits from the top.
// Divide: restoring step, {acc, q} shifts left, q collects quotient bits.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Select between add-and-shift-right and trial-subtract-and-shift-left
  always_comb begin
    sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
    shifted = {acc_i, q_i[WIDTH-1]};
    diff    = shifted - {1'b0, m_i};
    acc_o   = sum[WIDTH:1];
    q_o     = {sum[0], q_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide unit behind EX.
// Runs MULT/MULTU/DIV/DIVU as PREP -> WIDTH RUN steps -> FIXUP, then writes
// HI/LO and pulses done. Stalls the pipeline when EX presents a new mul/div
// or an MFHI/MFLO while an operation is in flight.
// Optional build macro MULDIV_PERF_EN adds saturating perf counters
// perf_stall_cnt and perf_ops.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_ctrl_if.slave bus
`ifdef MULDIV_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_ops
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             negLo_q, negHi_q;
  logic             done_q, dbz_q;

  logic             isDiv, isSigned, bZero;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH-1:0] accStep, qStep;
  logic [WIDTH-1:0] fixHi, fixLo;
  logic             fixDbz;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic             busyW, stallW;

  // Decode the latched operation and form operand magnitudes for signed ops
  always_comb begin
    isDiv    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    isSigned = (op_q == OP_MULT) || (op_q == OP_DIV);
    bZero    = (b_q == '0);
    magA     = (isSigned && a_q[WIDTH-1]) ? -a_q : a_q;
    magB     = (isSigned && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (isDiv),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .m_i      (m_q),
    .acc_o    (accStep),
    .q_o      (qStep)
  );

  // Sign correction and divide-by-zero override applied in FIXUP
  always_comb begin
    prod    = {acc_q, q_q};
    prodFix = negLo_q ? -prod : prod;
    fixHi   = prodFix[2*WIDTH-1:WIDTH];
    fixLo   = prodFix[WIDTH-1:0];
    fixDbz  = 1'b0;
    if (isDiv) begin
      if (bZero) begin
        fixHi  = a_q;
        fixLo  = '1;
        fixDbz = 1'b1;
      end else begin
        fixHi = negHi_q ? -acc_q : acc_q;
        fixLo = negLo_q ? -q_q : q_q;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; flush returns to IDLE from anywhere and beats start
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) state_d = S_PREP;
        S_PREP:  state_d = S_RUN;
        S_RUN:   if (cnt_q == CW'(WIDTH-1)) state_d = S_FIXUP;
        S_FIXUP: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: busy while not idle, stall only when EX needs the unit
  always_comb begin
    busyW  = (state_q != S_IDLE);
    stallW = busyW & (bus.start | bus.hilo_rd);
  end

  // Datapath: operand latch, iteration registers, HI/LO and result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      negLo_q <= 1'b0;
      negHi_q <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (!bus.flush) begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              op_q <= op_e'(bus.op);
              a_q  <= bus.src_a;
              b_q  <= bus.src_b;
            end
          end
          S_PREP: begin
            cnt_q <= '0;
            acc_q <= '0;
            if (isDiv) begin
              q_q     <= magA;
              m_q     <= magB;
              negHi_q <= isSigned & a_q[WIDTH-1];
            end else begin
              q_q     <= magB;
              m_q     <= magA;
              negHi_q <= 1'b0;
            end
            negLo_q <= isSigned & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          end
          S_RUN: begin
            acc_q <= accStep;
            q_q   <= qStep;
            cnt_q <= cnt_q + CW'(1);
          end
          S_FIXUP: begin
            hi_q   <= fixHi;
            lo_q   <= fixLo;
            done_q <= 1'b1;
            dbz_q  <= fixDbz;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy        = busyW;
  assign bus.stall       = stallW;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

`ifdef MULDIV_PERF_EN
  logic [31:0] stallCnt_q, opsCnt_q;

  // Saturating counters of stall cycles and completed operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      opsCnt_q   <= '0;
    end else begin
      if (stallW && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 32'd1;
      if (done_q && (opsCnt_q != '1))   opsCnt_q   <= opsCnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stallCnt_q;
  assign perf_ops       = opsCnt_q;
`endif

endmodule
